// File: rtl/rect_pkg.sv
// rect_pkg: shared widths, command/state types and bit mapping for the rectangle-flip sequencer.
package rect_pkg;
    localparam int MAT_W = 16;
    localparam int IDX_W = 2;
    localparam int CNT_W = 8;
    typedef struct packed {
        logic [IDX_W-1:0] r1;
        logic [IDX_W-1:0] r2;
        logic [IDX_W-1:0] c1;
        logic [IDX_W-1:0] c2;
        logic             last;
    } rect_cmd_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} sched_state_e;
    // Column-major with (0,0) at the MSB; {c,r} is c*ROWS+r for the 4x4 matrix
    function automatic logic [3:0] bit_index(input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] c);
        return 4'(MAT_W - 1) - {c, r};
    endfunction
endpackage

// File: rtl/rect_flip_sched_if.sv
// rect_flip_sched_if: load, command and result handshakes of the rectangle-flip sequencer.
interface rect_flip_sched_if;
    import rect_pkg::*;
    logic             load_valid, load_ready;
    logic [MAT_W-1:0] load_matrix;
    logic             cmd_valid, cmd_ready, cmd_last;
    logic [IDX_W-1:0] cmd_r1, cmd_r2, cmd_c1, cmd_c2;
    logic             res_valid, res_ready;
    logic [MAT_W-1:0] res_matrix;
    logic [CNT_W-1:0] res_applied, res_rejected;
    logic             busy;
    modport master (
        output load_valid, load_matrix, cmd_valid, cmd_r1, cmd_r2, cmd_c1, cmd_c2, cmd_last, res_ready,
        input  load_ready, cmd_ready, res_valid, res_matrix, res_applied, res_rejected, busy
    );
    modport slave (
        input  load_valid, load_matrix, cmd_valid, cmd_r1, cmd_r2, cmd_c1, cmd_c2, cmd_last, res_ready,
        output load_ready, cmd_ready, res_valid, res_matrix, res_applied, res_rejected, busy
    );
endinterface

// File: rtl/rect_cmd_fifo.sv
// rect_cmd_fifo: synchronous command FIFO with registered full/empty and same-cycle push/pop.
module rect_cmd_fifo import rect_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clr,
    input  logic      push,
    input  logic      pop,
    input  rect_cmd_t din,
    output rect_cmd_t dout,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;
    rect_cmd_t mem [DEPTH];
    ptr_t wr, rd, wr_nx, rd_nx;
    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_nx   = wr + ptr_t'(do_push);
    assign rd_nx   = rd + ptr_t'(do_pop);
    assign dout    = mem[rd[AW-1:0]];
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr    <= '0;
            rd    <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            wr    <= wr_nx;
            rd    <= rd_nx;
            full  <= wr_nx == {~rd_nx[AW], rd_nx[AW-1:0]};
            empty <= wr_nx == rd_nx;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/rect_flip_sched.sv
// rect_flip_sched: loads a 4x4 bit matrix, applies queued rectangle flips one per cycle,
// and returns the final matrix with applied/rejected counts.
module rect_flip_sched import rect_pkg::*; #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input logic             clk,
    input logic             rst_n,
    rect_flip_sched_if.slave bus
);
    if (ROWS * COLS != MAT_W) begin : g_bad_shape
        $error("rect_flip_sched: ROWS*COLS must equal 16");
    end
    sched_state_e     state, state_nx;
    logic [MAT_W-1:0] matrix, mask;
    logic [CNT_W-1:0] applied, rejected;
    logic             last_seen, full, empty, load, push, pop, degen;
    rect_cmd_t        head, cmd_in;
    assign cmd_in = '{r1: bus.cmd_r1, r2: bus.cmd_r2, c1: bus.cmd_c1, c2: bus.cmd_c2, last: bus.cmd_last};
    assign degen  = head.r1 == head.r2 || head.c1 == head.c2;
    // OR of the four corners; a degenerate rectangle would alias corners, but it is never applied
    assign mask = (MAT_W'(1) << bit_index(head.r1, head.c1)) | (MAT_W'(1) << bit_index(head.r1, head.c2))
                | (MAT_W'(1) << bit_index(head.r2, head.c1)) | (MAT_W'(1) << bit_index(head.r2, head.c2));
    assign bus.res_matrix   = matrix;
    assign bus.res_applied  = applied;
    assign bus.res_rejected = rejected;
    rect_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .clr(load), .push(push), .pop(pop),
        .din(cmd_in), .dout(head), .full(full), .empty(empty)
    );
    always_comb begin
        state_nx       = state;
        bus.load_ready = 1'b0;
        bus.cmd_ready  = 1'b0;
        bus.res_valid  = 1'b0;
        bus.busy       = 1'b0;
        load           = 1'b0;
        pop            = 1'b0;
        case (state)
            IDLE: begin
                bus.load_ready = 1'b1;
                load           = bus.load_valid;
                state_nx       = load ? RUN : IDLE;
            end
            RUN: begin
                bus.busy      = 1'b1;
                bus.cmd_ready = !full && !last_seen;
                pop           = !empty;
                state_nx      = pop && head.last ? DONE : RUN;
            end
            default: begin
                bus.busy      = 1'b1;
                bus.res_valid = 1'b1;
                state_nx      = bus.res_ready ? IDLE : DONE;
            end
        endcase
    end
    assign push = bus.cmd_valid && bus.cmd_ready;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            matrix    <= '0;
            applied   <= '0;
            rejected  <= '0;
            last_seen <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) begin
                matrix    <= bus.load_matrix;
                applied   <= '0;
                rejected  <= '0;
                last_seen <= 1'b0;
            end else begin
                if (push && bus.cmd_last) last_seen <= 1'b1;
                if (pop && degen && ~&rejected) rejected <= rejected + CNT_W'(1);
                if (pop && !degen) begin
                    matrix <= matrix ^ mask;
                    if (~&applied) applied <= applied + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_rect_flip_sched.sv
// tb_rect_flip_sched: randomized and directed checks of rect_flip_sched against a matrix-level model.
module tb_rect_flip_sched;
    typedef struct {int r1; int r2; int c1; int c2; bit last;} tcmd_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int passed = 0;
    rect_flip_sched_if bus();
    rect_flip_sched #(.ROWS(4), .COLS(4), .FIFO_DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    // Model: element (r,c) lives at bit 15-(c*4+r); degenerate rectangles leave the matrix alone
    function automatic logic [15:0] flip_ref(input logic [15:0] m, input tcmd_t c);
        logic [15:0] k;
        if (c.r1 == c.r2 || c.c1 == c.c2) return m;
        k = '0;
        k[15 - (c.c1 * 4 + c.r1)] = 1'b1;
        k[15 - (c.c2 * 4 + c.r1)] = 1'b1;
        k[15 - (c.c1 * 4 + c.r2)] = 1'b1;
        k[15 - (c.c2 * 4 + c.r2)] = 1'b1;
        return m ^ k;
    endfunction

    function automatic tcmd_t mk(input int r1, input int r2, input int c1, input int c2, input bit last);
        tcmd_t c;
        c.r1 = r1; c.r2 = r2; c.c1 = c1; c.c2 = c2; c.last = last;
        return c;
    endfunction

    function automatic tcmd_t rand_cmd(input int deg_pct, input bit last);
        tcmd_t c;
        c.r1 = $urandom_range(3);
        c.c1 = $urandom_range(3);
        c.r2 = (c.r1 + $urandom_range(3, 1)) % 4;
        c.c2 = (c.c1 + $urandom_range(3, 1)) % 4;
        if ($urandom_range(99) < deg_pct) begin
            if ($urandom_range(1) == 1) c.r2 = c.r1;
            else c.c2 = c.c1;
        end
        c.last = last;
        return c;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] m);
        bus.load_matrix = m;
        bus.load_valid  = 1'b1;
        tick();
        bus.load_valid  = 1'b0;
    endtask

    task automatic send(input tcmd_t c, inout int stalls);
        logic rdy;
        bus.cmd_r1 = 2'(c.r1); bus.cmd_r2 = 2'(c.r2);
        bus.cmd_c1 = 2'(c.c1); bus.cmd_c2 = 2'(c.c2);
        bus.cmd_last  = c.last;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rdy = bus.cmd_ready;
            tick();
            if (rdy) return;
            stalls++;
        end
        checks++;
        $display("FAIL send_timeout: cmd_ready stayed 0, required 1 within 20 cycles");
    endtask

    // Loads m0, streams q (optionally with idle gaps) and returns the model's expected result
    task automatic run_job(input logic [15:0] m0, input tcmd_t q[$], input bit gaps,
                           output logic [15:0] em, output int ea, output int er, inout int stalls);
        em = m0; ea = 0; er = 0;
        do_load(m0);
        foreach (q[i]) begin
            send(q[i], stalls);
            if (q[i].r1 == q[i].r2 || q[i].c1 == q[i].c2) er = er < 255 ? er + 1 : 255;
            else ea = ea < 255 ? ea + 1 : 255;
            em = flip_ref(em, q[i]);
            if (gaps && $urandom_range(2) == 0) begin
                bus.cmd_valid = 1'b0;
                tick();
            end
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.res_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
        checks++;
        $display("FAIL result_timeout: res_valid=0, required 1 within 30 cycles");
    endtask

    task automatic release_res;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.load_valid = 1'b1;
        tick();
        tick();
        bus.cmd_valid = 1'b0;
        bus.load_valid = 1'b0;
        checks++; if (bus.load_ready !== 1'b1) $display("FAIL reset_load_ready: got %b, required 1", bus.load_ready); else passed++;
        checks++; if (bus.cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b, required 0", bus.cmd_ready); else passed++;
        checks++; if (bus.res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b, required 0", bus.res_valid); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", bus.busy); else passed++;
        checks++; if (bus.res_matrix !== 16'h0) $display("FAIL reset_matrix: got %h, required 0000", bus.res_matrix); else passed++;
        checks++; if (bus.res_applied !== 8'd0 || bus.res_rejected !== 8'd0)
            $display("FAIL reset_counts: got %0d/%0d, required 0/0", bus.res_applied, bus.res_rejected); else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_latency;
        int stalls = 0;
        bit ok;
        do_load(16'h0000);
        checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b1 || bus.load_ready !== 1'b0)
            $display("FAIL load_to_run: got cmd_ready=%b busy=%b load_ready=%b, required 1 1 0", bus.cmd_ready, bus.busy, bus.load_ready); else passed++;
        send(mk(0, 1, 0, 1, 1), stalls);
        bus.cmd_valid = 1'b0;
        checks++; if (bus.res_valid !== 1'b0) $display("FAIL latency_early: res_valid got %b one cycle after accept, required 0", bus.res_valid); else passed++;
        tick();
        checks++; if (bus.res_valid !== 1'b1) $display("FAIL latency_two: res_valid got %b two cycles after accept, required 1", bus.res_valid); else passed++;
        wait_valid(ok);
        if (ok) begin
            checks++; if (bus.res_matrix !== 16'hCC00 || bus.res_applied !== 8'd1 || bus.res_rejected !== 8'd0)
                $display("FAIL latency_result: got %h/%0d/%0d, required cc00/1/0", bus.res_matrix, bus.res_applied, bus.res_rejected); else passed++;
            release_res();
        end
        checks++; if (bus.load_ready !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL done_to_idle: got load_ready=%b busy=%b, required 1 0", bus.load_ready, bus.busy); else passed++;
    endtask

    task automatic test_plan;
        logic [15:0] m0 [3] = '{16'hFFFF, 16'h1234, 16'hA5A5};
        logic [15:0] want [3] = '{16'h6FF6, 16'h1234, 16'h69A5};
        int wa [3] = '{1, 2, 1};
        int wr [3] = '{0, 0, 1};
        for (int t = 0; t < 3; t++) begin
            tcmd_t q[$];
            logic [15:0] em;
            int ea, er;
            int stalls = 0;
            bit ok;
            if (t == 0) q = '{mk(3, 0, 3, 0, 1)};
            else if (t == 1) q = '{mk(0, 2, 1, 3, 0), mk(0, 2, 1, 3, 1)};
            else q = '{mk(2, 2, 0, 3, 0), mk(0, 1, 0, 1, 1)};
            run_job(m0[t], q, 1'b0, em, ea, er, stalls);
            wait_valid(ok);
            if (ok) begin
                checks++; if (bus.res_matrix !== want[t] || bus.res_applied !== 8'(wa[t]) || bus.res_rejected !== 8'(wr[t]))
                    $display("FAIL plan%0d: got %h/%0d/%0d, required %h/%0d/%0d", t, bus.res_matrix, bus.res_applied,
                             bus.res_rejected, want[t], wa[t], wr[t]); else passed++;
                release_res();
            end
        end
    endtask

    task automatic test_back_to_back;
        tcmd_t q[$];
        logic [15:0] em, held;
        int ea, er;
        int stalls = 0;
        bit ok;
        for (int i = 0; i < 8; i++) q.push_back(rand_cmd(20, i == 7));
        bus.res_ready = 1'b0;
        run_job(16'($urandom), q, 1'b0, em, ea, er, stalls);
        checks++; if (stalls !== 0) $display("FAIL b2b_stalls: got %0d stall cycles, required 0", stalls); else passed++;
        wait_valid(ok);
        if (ok) begin
            checks++; if (bus.res_matrix !== em || bus.res_applied !== 8'(ea) || bus.res_rejected !== 8'(er))
                $display("FAIL b2b_result: got %h/%0d/%0d, required %h/%0d/%0d", bus.res_matrix, bus.res_applied,
                         bus.res_rejected, em, ea, er); else passed++;
            held = bus.res_matrix;
            bus.cmd_valid = 1'b1;
            bus.load_valid = 1'b1;
            bus.load_matrix = ~held;
            for (int i = 0; i < 4; i++) begin
                tick();
                checks++; if (bus.res_valid !== 1'b1 || bus.res_matrix !== held || bus.load_ready !== 1'b0 || bus.cmd_ready !== 1'b0)
                    $display("FAIL done_hold%0d: got valid=%b matrix=%h load_ready=%b cmd_ready=%b, required 1 %h 0 0",
                             i, bus.res_valid, bus.res_matrix, bus.load_ready, bus.cmd_ready, held); else passed++;
            end
            bus.cmd_valid = 1'b0;
            release_res();
            bus.load_valid = 1'b0;
            checks++; if (bus.res_valid !== 1'b0 || bus.load_ready !== 1'b1 || bus.res_matrix !== held)
                $display("FAIL b2b_release: got valid=%b load_ready=%b matrix=%h, required 0 1 %h",
                         bus.res_valid, bus.load_ready, bus.res_matrix, held); else passed++;
        end
    endtask

    task automatic test_random;
        for (int j = 0; j < 6; j++) begin
            tcmd_t q[$];
            logic [15:0] em;
            int ea, er;
            int stalls = 0;
            int n = $urandom_range(10, 1);
            bit ok;
            for (int i = 0; i < n; i++) q.push_back(rand_cmd(25, i == n - 1));
            bus.res_ready = $urandom_range(1) == 1;
            run_job(16'($urandom), q, 1'b1, em, ea, er, stalls);
            wait_valid(ok);
            if (ok) begin
                checks++; if (bus.res_matrix !== em || bus.res_applied !== 8'(ea) || bus.res_rejected !== 8'(er))
                    $display("FAIL random%0d: got %h/%0d/%0d, required %h/%0d/%0d", j, bus.res_matrix, bus.res_applied,
                             bus.res_rejected, em, ea, er); else passed++;
                release_res();
            end
        end
    endtask

    task automatic test_saturation;
        tcmd_t q[$];
        logic [15:0] em;
        int ea, er;
        int stalls = 0;
        bit ok;
        for (int i = 0; i < 600; i++) q.push_back(rand_cmd(50, i == 599));
        run_job(16'($urandom), q, 1'b0, em, ea, er, stalls);
        wait_valid(ok);
        if (ok) begin
            checks++; if (bus.res_matrix !== em || bus.res_applied !== 8'(ea) || bus.res_rejected !== 8'(er))
                $display("FAIL saturation: got %h/%0d/%0d, required %h/%0d/%0d", bus.res_matrix, bus.res_applied,
                         bus.res_rejected, em, ea, er); else passed++;
            release_res();
        end
    endtask

    task automatic test_mid_reset;
        tcmd_t q[$];
        logic [15:0] em;
        int ea, er;
        int stalls = 0;
        bit ok;
        bus.cmd_r1 = 2'd0; bus.cmd_r2 = 2'd3; bus.cmd_c1 = 2'd0; bus.cmd_c2 = 2'd3;
        bus.cmd_last = 1'b1;
        bus.cmd_valid = 1'b1;
        tick();
        checks++; if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL idle_cmd_ignored: got cmd_ready=%b busy=%b, required 0 0", bus.cmd_ready, bus.busy); else passed++;
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) q.push_back(rand_cmd(0, 1'b0));
        run_job(16'hBEEF, q, 1'b0, em, ea, er, stalls);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (bus.load_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b0)
            $display("FAIL midreset_state: got load_ready=%b valid=%b busy=%b cmd_ready=%b, required 1 0 0 0",
                     bus.load_ready, bus.res_valid, bus.busy, bus.cmd_ready); else passed++;
        checks++; if (bus.res_applied !== 8'd0 || bus.res_rejected !== 8'd0 || bus.res_matrix !== 16'h0)
            $display("FAIL midreset_counts: got %h/%0d/%0d, required 0000/0/0", bus.res_matrix, bus.res_applied, bus.res_rejected); else passed++;
        q = '{mk(1, 3, 0, 2, 1)};
        run_job(16'h0F0F, q, 1'b0, em, ea, er, stalls);
        wait_valid(ok);
        if (ok) begin
            checks++; if (bus.res_matrix !== em || bus.res_applied !== 8'd1 || bus.res_rejected !== 8'd0)
                $display("FAIL midreset_after: got %h/%0d/%0d, required %h/1/0", bus.res_matrix, bus.res_applied,
                         bus.res_rejected, em); else passed++;
            release_res();
        end
    endtask

    initial begin
        bus.load_valid = 1'b0; bus.load_matrix = '0;
        bus.cmd_valid = 1'b0; bus.cmd_last = 1'b0;
        bus.cmd_r1 = '0; bus.cmd_r2 = '0; bus.cmd_c1 = '0; bus.cmd_c2 = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_latency();
        test_plan();
        test_back_to_back();
        test_random();
        test_saturation();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/rect_flip_sched.md
# rect_flip_sched

Sequencer for the 4x4 rectangle-flip datapath. It accepts an initial bit matrix, then a stream of rectangle commands over a valid/ready handshake, buffered in a small FIFO. Commands are applied one per cycle to an internal matrix register; degenerate rectangles are rejected. The block returns the final matrix and command statistics when the command flagged last has been processed. It sits between the host or command generator and the flip datapath in the Rectangle Loop design.

## Interface
- ROWS, 4, matrix rows; elaboration-time check ROWS*COLS == 16
- COLS, 4, matrix columns
- FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- load_valid / load_ready  in/out  1  initial-matrix handshake
- load_matrix  in  16  initial matrix
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_r1, cmd_r2, cmd_c1, cmd_c2  in  2 each  rectangle corner rows/cols
- cmd_last  in  1  final command of the job
- res_valid / res_ready  out/in  1  result handshake
- res_matrix  out  16  final matrix
- res_applied  out  8  commands applied, saturating at 255
- res_rejected  out  8  commands rejected, saturating at 255
- busy  out  1  high in RUN or DONE

## Operation
- Bit mapping: element (r,c) is matrix bit 15 − (c*ROWS + r), i.e. column-major with MSB = (0,0).
- Flip: mask = OR of four one-hot bits at (r1,c1), (r1,c2), (r2,c1), (r2,c2); matrix ← matrix XOR mask. Use OR, not addition.
- Degenerate command (r1==r2 or c1==c2):
  - rejected;
  - matrix unchanged;
  - res_rejected increments.
- States: IDLE, RUN, DONE.
  - IDLE: load_ready=1, cmd_ready=0. On load handshake: matrix ← load_matrix, counters ← 0, FIFO cleared, last_seen ← 0, go to RUN.
  - RUN: cmd_ready = !fifo_full && !last_seen. A command is accepted on cmd_valid&&cmd_ready and pushed to the FIFO. An accepted command with cmd_last=1 sets last_seen.
  - RUN, pop: when the FIFO is non-empty, pop the head and apply (or reject) it in that same cycle.
  - RUN, exit: when the popped entry carries last, go to DONE.
  - DONE: res_valid=1, with res_* held stable. On res_ready, go to IDLE. load_ready=0 and cmd_ready=0.
- Push and pop may occur in the same cycle. cmd_ready depends only on the registered full flag, with no bypass. A command is never applied in its acceptance cycle.
- cmd_valid outside RUN is ignored. A load_valid outside IDLE is ignored (held off by load_ready=0).

## Timing
- Reset values:
  - state=IDLE, load_ready=1, cmd_ready=0;
  - res_valid=0, res_matrix=0, res_applied=0, res_rejected=0, busy=0;
  - FIFO empty.
- Load handshake in cycle N: RUN and cmd_ready=1 in cycle N+1.
- Command accepted in cycle N: earliest pop/apply in cycle N+1; matrix updated at the end of N+1.
- Last command popped in cycle M: res_valid=1 in cycle M+1, reflecting every apply up to and including M.
- Throughput: one command per cycle sustained. With FIFO_DEPTH entries, back-to-back input never stalls, because pop keeps pace.
- Full FIFO: cmd_ready=0 in the following cycle until a pop frees an entry. Any entry pushed before full asserted is kept; nothing is dropped.
- Counter saturation: at 255 the counter holds; further commands are still applied or rejected normally.
- res_ready may be asserted early; it has effect only in DONE.
- rst_n low in any state, including mid-RUN with a non-empty FIFO: all outputs return to their reset values at the next edge, and queued commands are discarded.

## Structure
- Package rect_pkg:
  - MAT_W=16, IDX_W=2, CNT_W=8;
  - typedef rect_cmd_t struct {r1, r2, c1, c2, last};
  - typedef sched_state_e {IDLE, RUN, DONE};
  - function bit_index(r,c) returning 15 − (c*ROWS + r).
- Sub-module rect_cmd_fifo: synchronous FIFO of rect_cmd_t with depth FIFO_DEPTH, registered full/empty, and simultaneous push/pop.
- Mask generation, the FSM and the counters stay in rect_flip_sched.

## Test plan
- Load 0x0000, then cmd (r1=0,r2=1,c1=0,c2=1,last=1) → res_matrix=0xCC00, applied=1, rejected=0. res_valid appears 2 cycles after cmd acceptance.
- Load 0xFFFF, then cmd (r1=3,r2=0,c1=3,c2=0,last=1) → res_matrix=0x6FF6.
- Load 0x1234, then the same rectangle (0,2,1,3) twice, last on the second → res_matrix=0x1234, applied=2.
- Load 0xA5A5, then cmd (r1=2,r2=2,c1=0,c2=3), then cmd (0,1,0,1,last) → rejected=1, applied=1, res_matrix=0xA5A5^0xCC00=0x69A5.
- Hold res_ready=0, stream 8 valid commands back-to-back → no command lost; apply order matches acceptance order. res_valid is held with stable data until res_ready; load_ready=0 throughout DONE.
- Assert rst_n=0 mid-RUN with 3 commands queued → next cycle: IDLE, res_valid=0, counters 0. A new load followed by one command gives a result unaffected by the discarded commands.
